// File: rtl/vproc_resp_pkg.sv
// Shared definitions for the VProc memory responder: FSM states, LFSR
// constants, burst counter width and the byte-lane mask helper.
package vproc_resp_pkg;

   localparam int BURST_W    = 12;
   // Wide enough for 15 programmed wait states plus up to 3 random extras.
   localparam int WAIT_CNT_W = 5;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } resp_state_t;

   // Expand 4 byte enables into a 32-bit bit mask.
   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/vproc_resp_ram.sv
// Byte-enabled single-port RAM: one byte-wide array per lane, synchronous
// write, registered read that holds its value until the next read.
module vproc_resp_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [3:0]            be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_reg;

         // Lane write: only this byte when its enable is set.
         always_ff @(posedge clk) begin
            if (we && be[gi]) begin
               mem[addr] <= wdata[8*gi +: 8];
            end
         end

         // Registered read; the output register alone is cleared by reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_reg <= '0;
            end else if (re) begin
               rd_reg <= mem[addr];
            end
         end

         assign rdata[8*gi +: 8] = rd_reg;
      end
   endgenerate

endmodule

// File: rtl/vproc_mem_responder.sv
// VProc bus responder backed by a word-wide RAM. Every request (single or
// burst beat) is acked once after WAIT_STATES cycles; out-of-window and
// protocol problems raise sticky flags. Optional macro
// VPROC_RESP_RAND_WAIT_EN adds 0..3 LFSR-chosen wait cycles per beat.
module vproc_mem_responder
   import vproc_resp_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WORD_ADDR   = 1,
   parameter int          WAIT_STATES = 0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [31:0]        Addr,
   input  logic [3:0]         BE,
   input  logic               WE,
   input  logic               RD,
   input  logic [31:0]        DataIn,
   input  logic [BURST_W-1:0] Burst,
   input  logic               BurstFirst,
   input  logic               BurstLast,
   output logic [31:0]        DataOut,
   output logic               WRAck,
   output logic               RDAck,
   output logic               AddrErr,
   output logic               ProtoErr
);

   resp_state_t           state_reg, state_next;
   logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next, wait_total;
   logic [BURST_W-1:0]    beat_reg, beat_next;
   logic                  wr_ack_reg, rd_ack_reg;
   logic                  addr_err_reg, proto_err_reg;
   logic                  zero_out_reg;
   logic                  req, fire, in_win, both_err, burst_err;
   logic [ADDR_WIDTH-1:0] word_index;
   logic [31:0]           ram_rdata;

   assign req = WE | RD;

   // Address decode: window tag above the index field, index wraps.
   generate
      if (WORD_ADDR != 0) begin : g_word
         assign word_index = Addr[ADDR_WIDTH-1:0];
         assign in_win     = (Addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
      end else begin : g_byte
         logic unused_byte_offset;
         assign unused_byte_offset = ^Addr[1:0];
         assign word_index = Addr[ADDR_WIDTH+1:2];
         assign in_win     = (Addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
      end
   endgenerate

`ifdef VPROC_RESP_RAND_WAIT_EN
   logic [15:0] lfsr_reg;

   // Free-running LFSR supplying 0..3 extra wait cycles per beat.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lfsr_reg <= LFSR_SEED;
      end else begin
         lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
      end
   end

   assign wait_total = WAIT_CNT_W'(WAIT_STATES) + WAIT_CNT_W'(lfsr_reg[1:0]);
`else
   assign wait_total = WAIT_CNT_W'(WAIT_STATES);
`endif

   // Next-state logic; fire marks the edge that commits/reads and sets the ack.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      fire       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               if (wait_total == '0) begin
                  state_next = ACK;
                  fire       = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = wait_total - 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               state_next = ACK;
               fire       = 1'b1;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ACK: begin
            // The request seen here belongs to the beat just acked.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Simultaneous WE and RD is serviced as a write but flagged.
   assign both_err = (state_reg == IDLE) && WE && RD;

   // Burst beat tracking; the check uses the count after this beat.
   always_comb begin
      beat_next = beat_reg;
      burst_err = 1'b0;
      if (fire && (Burst != '0)) begin
         if (BurstFirst) begin
            beat_next = Burst - 1'b1;
            if (beat_reg != '0) begin
               burst_err = 1'b1;
            end
         end else if (beat_reg != '0) begin
            beat_next = beat_reg - 1'b1;
         end
         if (BurstFirst || (beat_reg != '0)) begin
            if (BurstLast != (beat_next == '0)) begin
               burst_err = 1'b1;
            end
         end
      end
   end

   // FSM, wait counter and burst counter registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         beat_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         beat_reg  <= beat_next;
      end
   end

   // Ack pulses, sticky error flags and the out-of-window read zeroing.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ack_reg    <= 1'b0;
         rd_ack_reg    <= 1'b0;
         addr_err_reg  <= 1'b0;
         proto_err_reg <= 1'b0;
         zero_out_reg  <= 1'b0;
      end else begin
         wr_ack_reg <= fire & WE;
         rd_ack_reg <= fire & ~WE;
         if (fire && !WE) begin
            zero_out_reg <= ~in_win;
         end
         if (fire && !in_win) begin
            addr_err_reg <= 1'b1;
         end
         if (both_err || burst_err) begin
            proto_err_reg <= 1'b1;
         end
      end
   end

   vproc_resp_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (Clk),
      .rst   (Reset),
      .we    (fire & WE & in_win),
      .re    (fire & ~WE & in_win),
      .be    (BE),
      .addr  (word_index),
      .wdata (DataIn),
      .rdata (ram_rdata)
   );

   assign DataOut  = zero_out_reg ? 32'h0 : ram_rdata;
   assign WRAck    = wr_ack_reg;
   assign RDAck    = rd_ack_reg;
   assign AddrErr  = addr_err_reg;
   assign ProtoErr = proto_err_reg;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Self-checking bench for vproc_mem_responder: one zero-wait instance and one
// three-wait instance, a behavioural memory model and an expectation queue.
module tb_vproc_mem_responder;
   import vproc_resp_pkg::*;

`ifdef VPROC_RESP_RAND_WAIT_EN
   localparam int EXTRA = 3;
`else
   localparam int EXTRA = 0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Addr = '0;
   logic [3:0]  BE = 4'hF;
   logic        WE = 1'b0;
   logic        RD = 1'b0;
   logic [31:0] DataIn = '0;
   logic [11:0] Burst = '0;
   logic        BurstFirst = 1'b0;
   logic        BurstLast = 1'b0;
   logic [31:0] DataOut;
   logic        WRAck, RDAck, AddrErr, ProtoErr;

   logic [31:0] addr_w3 = '0;
   logic        we_w3 = 1'b0;
   logic        rd_w3 = 1'b0;
   logic [31:0] data_in_w3 = '0;
   logic [31:0] data_out_w3;
   logic        wr_ack_w3, rd_ack_w3, addr_err_w3, proto_err_w3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } op_t;

   logic [31:0] model_mem [int];

   always #5 Clk = ~Clk;

   vproc_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WORD_ADDR(1), .WAIT_STATES(0)) dut0 (
      .Clk(Clk), .Reset(Reset), .Addr(Addr), .BE(BE), .WE(WE), .RD(RD), .DataIn(DataIn),
      .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast), .DataOut(DataOut),
      .WRAck(WRAck), .RDAck(RDAck), .AddrErr(AddrErr), .ProtoErr(ProtoErr));

   vproc_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WORD_ADDR(1), .WAIT_STATES(3)) dut3 (
      .Clk(Clk), .Reset(Reset), .Addr(addr_w3), .BE(4'hF), .WE(we_w3), .RD(rd_w3), .DataIn(data_in_w3),
      .Burst(12'd0), .BurstFirst(1'b0), .BurstLast(1'b0), .DataOut(data_out_w3),
      .WRAck(wr_ack_w3), .RDAck(rd_ack_w3), .AddrErr(addr_err_w3), .ProtoErr(proto_err_w3));

   function automatic bit in_window(input logic [31:0] a);
      return a[31:10] == 22'h0;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] old;
      int idx;
      if (in_window(a)) begin
         idx = int'(a[9:0]);
         old = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
         model_mem[idx] = (old & ~be_mask(be)) | (d & be_mask(be));
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int idx;
      idx = int'(a[9:0]);
      if (!in_window(a)) return 32'h0;
      return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
   endfunction

   task automatic push_exp(input logic wr, input logic [31:0] data);
      exp_t e;
      e.wr = wr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Drive one request (sel=1 targets dut3) and report what came back.
   task automatic access(input bit sel, input logic wr, input logic rd, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic [11:0] bl,
                         input logic bf, input logic blst, output int lat, output logic gw,
                         output logic gr, output logic [31:0] dout);
      @(negedge Clk);
      if (sel) begin
         addr_w3 = a; data_in_w3 = d; we_w3 = wr; rd_w3 = rd;
      end else begin
         Addr = a; BE = be; DataIn = d; Burst = bl; BurstFirst = bf; BurstLast = blst;
         WE = wr; RD = rd;
      end
      lat = -1; gw = 1'b0; gr = 1'b0; dout = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (sel ? (wr_ack_w3 || rd_ack_w3) : (WRAck || RDAck)) begin
            lat  = i;
            gw   = sel ? wr_ack_w3 : WRAck;
            gr   = sel ? rd_ack_w3 : RDAck;
            dout = sel ? data_out_w3 : DataOut;
            break;
         end
      end
      if (sel) begin
         we_w3 = 1'b0; rd_w3 = 1'b0;
      end else begin
         WE = 1'b0; RD = 1'b0; Burst = '0; BurstFirst = 1'b0; BurstLast = 1'b0;
      end
      $display("  access dut%0d wr=%0b rd=%0b addr=%h data=%h lat=%0d ack_wr=%0b ack_rd=%0b dout=%h",
               sel ? 3 : 0, wr, rd, a, d, lat, gw, gr, dout);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1; WE = 1'b0; RD = 1'b0; we_w3 = 1'b0; rd_w3 = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge Clk);
      checks++;
      if ({DataOut, WRAck, RDAck, AddrErr, ProtoErr} !== 36'h0) begin
         errors++;
         $display("FAIL reset_dut0: got data=%h wr=%b rd=%b ae=%b pe=%b required all 0", DataOut, WRAck, RDAck, AddrErr, ProtoErr);
      end
      checks++;
      if ({data_out_w3, wr_ack_w3, rd_ack_w3, addr_err_w3, proto_err_w3} !== 36'h0) begin
         errors++;
         $display("FAIL reset_dut3: got data=%h wr=%b rd=%b ae=%b pe=%b required all 0", data_out_w3, wr_ack_w3, rd_ack_w3, addr_err_w3, proto_err_w3);
      end
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_single();
      op_t ops[2];
      exp_t e;
      int lat;
      logic gw, gr;
      logic [31:0] dout;
      ops[0] = '{1'b1, 1'b0, 32'd5, 4'hF, 32'hDEADBEEF};
      ops[1] = '{1'b0, 1'b1, 32'd5, 4'hF, 32'h0};
      for (int k = 0; k < 2; k++) begin
         if (ops[k].wr) begin
            push_exp(1'b1, 32'h0);
            model_write(ops[k].a, ops[k].be, ops[k].d);
         end else begin
            push_exp(1'b0, model_read(ops[k].a));
         end
         access(1'b0, ops[k].wr, ops[k].rd, ops[k].a, ops[k].be, ops[k].d, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
         e = exp_q.pop_front();
         checks++;
         if (gw !== e.wr || gr !== !e.wr) begin
            errors++;
            $display("FAIL single_ack_type op%0d: got wr=%b rd=%b required wr=%b", k, gw, gr, e.wr);
         end
         checks++;
         if (lat < 0 || lat > EXTRA) begin
            errors++;
            $display("FAIL single_latency op%0d: got %0d required 0..%0d", k, lat, EXTRA);
         end
         if (!e.wr) begin
            checks++;
            if (dout !== e.data) begin
               errors++;
               $display("FAIL single_read_data: got %h required %h", dout, e.data);
            end
         end
      end
      @(negedge Clk);
      checks++;
      if (DataOut !== model_read(32'd5) || RDAck !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: got data=%h rdack=%b required data=%h rdack=0", DataOut, RDAck, model_read(32'd5));
      end
   endtask

   task automatic test_byte_enables();
      op_t ops[3];
      exp_t e;
      int lat;
      logic gw, gr;
      logic [31:0] dout;
      ops[0] = '{1'b1, 1'b0, 32'd7, 4'hF,    32'h11223344};
      ops[1] = '{1'b1, 1'b0, 32'd7, 4'b0101, 32'hAABBCCDD};
      ops[2] = '{1'b0, 1'b1, 32'd7, 4'hF,    32'h0};
      for (int k = 0; k < 3; k++) begin
         if (ops[k].wr) begin
            push_exp(1'b1, 32'h0);
            model_write(ops[k].a, ops[k].be, ops[k].d);
         end else begin
            push_exp(1'b0, model_read(ops[k].a));
         end
         access(1'b0, ops[k].wr, ops[k].rd, ops[k].a, ops[k].be, ops[k].d, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
         e = exp_q.pop_front();
         checks++;
         if (gw !== e.wr || gr !== !e.wr) begin
            errors++;
            $display("FAIL be_ack_type op%0d: got wr=%b rd=%b required wr=%b", k, gw, gr, e.wr);
         end
         if (!e.wr) begin
            checks++;
            if (dout !== e.data) begin
               errors++;
               $display("FAIL be_read_data: got %h required %h", dout, e.data);
            end
         end
      end
   endtask

   task automatic test_burst();
      int cyc, prev, lat;
      bit found;
      exp_t e;
      logic gw, gr;
      logic [31:0] dout;
      cyc = 0;
      prev = 0;
      @(negedge Clk);
      WE = 1'b1; BE = 4'hF; Burst = 12'd4;
      for (int b = 0; b < 4; b++) begin
         Addr = 32'(16 + b); DataIn = 32'(b + 1);
         BurstFirst = (b == 0); BurstLast = (b == 3);
         model_write(Addr, 4'hF, DataIn);
         found = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            cyc++;
            if (WRAck) begin
               found = 1'b1;
               break;
            end
         end
         $display("  burst beat %0d addr=%0d found=%0b cycle=%0d", b, 16 + b, found, cyc);
         checks++;
         if (!found || (b > 0 && (cyc - prev) < 2)) begin
            errors++;
            $display("FAIL burst_beat%0d: got found=%0b gap=%0d required ack with gap>=2", b, found, cyc - prev);
         end
         prev = cyc;
      end
      WE = 1'b0; Burst = '0; BurstFirst = 1'b0; BurstLast = 1'b0;
      for (int b = 0; b < 4; b++) begin
         push_exp(1'b0, model_read(32'(16 + b)));
         access(1'b0, 1'b0, 1'b1, 32'(16 + b), 4'hF, 32'h0, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
         e = exp_q.pop_front();
         checks++;
         if (gr !== 1'b1 || dout !== e.data) begin
            errors++;
            $display("FAIL burst_readback%0d: got rdack=%b data=%h required rdack=1 data=%h", b, gr, dout, e.data);
         end
      end
      checks++;
      if (ProtoErr !== 1'b0) begin
         errors++;
         $display("FAIL burst_protoerr: got %b required 0", ProtoErr);
      end
   endtask

   task automatic test_wait_states();
      int lat;
      int late_acks;
      logic gw, gr;
      logic [31:0] dout;
      access(1'b1, 1'b1, 1'b0, 32'd3, 4'hF, 32'h5A5A1234, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
      checks++;
      if (gw !== 1'b1 || lat < 3 || lat > 3 + EXTRA) begin
         errors++;
         $display("FAIL wait_write: got wrack=%b lat=%0d required wrack=1 lat 3..%0d", gw, lat, 3 + EXTRA);
      end
      @(negedge Clk);
      addr_w3 = 32'd3; rd_w3 = 1'b1;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (wr_ack_w3 || rd_ack_w3) begin
            lat = i;
            break;
         end
      end
      $display("  wait read addr=3 lat=%0d rdack=%0b data=%h", lat, rd_ack_w3, data_out_w3);
      checks++;
      if (lat < 3 || lat > 3 + EXTRA) begin
         errors++;
         $display("FAIL wait_read_latency: got %0d required 3..%0d", lat, 3 + EXTRA);
      end
      checks++;
      if (rd_ack_w3 !== 1'b1 || data_out_w3 !== 32'h5A5A1234) begin
         errors++;
         $display("FAIL wait_read_data: got rdack=%b data=%h required rdack=1 data=5a5a1234", rd_ack_w3, data_out_w3);
      end
      @(negedge Clk);
      checks++;
      if (rd_ack_w3 !== 1'b0 || wr_ack_w3 !== 1'b0) begin
         errors++;
         $display("FAIL wait_ack_width: got rdack=%b wrack=%b one cycle later required 0", rd_ack_w3, wr_ack_w3);
      end
      rd_w3 = 1'b0;
      late_acks = 0;
      repeat (8) begin
         @(negedge Clk);
         if (rd_ack_w3 || wr_ack_w3) late_acks++;
      end
      checks++;
      if (late_acks != 0) begin
         errors++;
         $display("FAIL wait_no_reservice: got %0d extra acks required 0", late_acks);
      end
   endtask

   task automatic test_errors();
      op_t ops[4];
      exp_t e;
      int lat;
      logic gw, gr;
      logic [31:0] dout;
      do_reset();
      push_exp(1'b1, 32'h0);
      model_write(32'd40, 4'hF, 32'hCAFEF00D);
      access(1'b0, 1'b1, 1'b1, 32'd40, 4'hF, 32'hCAFEF00D, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
      e = exp_q.pop_front();
      checks++;
      if (gw !== e.wr || gr !== 1'b0 || ProtoErr !== 1'b1) begin
         errors++;
         $display("FAIL we_rd_both: got wr=%b rd=%b pe=%b required wr=1 rd=0 pe=1", gw, gr, ProtoErr);
      end
      push_exp(1'b0, model_read(32'd40));
      access(1'b0, 1'b0, 1'b1, 32'd40, 4'hF, 32'h0, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
      e = exp_q.pop_front();
      checks++;
      if (gr !== 1'b1 || dout !== e.data) begin
         errors++;
         $display("FAIL we_rd_commit: got rdack=%b data=%h required rdack=1 data=%h", gr, dout, e.data);
      end
      do_reset();
      checks++;
      if (ProtoErr !== 1'b0) begin
         errors++;
         $display("FAIL protoerr_clear: got %b required 0", ProtoErr);
      end
      model_write(32'd30, 4'hF, 32'h30);
      access(1'b0, 1'b1, 1'b0, 32'd30, 4'hF, 32'h30, 12'd3, 1'b1, 1'b0, lat, gw, gr, dout);
      checks++;
      if (gw !== 1'b1 || ProtoErr !== 1'b0) begin
         errors++;
         $display("FAIL burst3_beat1: got wrack=%b pe=%b required wrack=1 pe=0", gw, ProtoErr);
      end
      model_write(32'd31, 4'hF, 32'h31);
      access(1'b0, 1'b1, 1'b0, 32'd31, 4'hF, 32'h31, 12'd3, 1'b0, 1'b1, lat, gw, gr, dout);
      checks++;
      if (gw !== 1'b1 || ProtoErr !== 1'b1) begin
         errors++;
         $display("FAIL burst3_early_last: got wrack=%b pe=%b required wrack=1 pe=1", gw, ProtoErr);
      end
      ops[0] = '{1'b0, 1'b1, 32'd5,         4'hF, 32'h0};
      ops[1] = '{1'b0, 1'b1, 32'h0000_0400, 4'hF, 32'h0};
      ops[2] = '{1'b1, 1'b0, 32'h0000_0405, 4'hF, 32'h0BAD0BAD};
      ops[3] = '{1'b0, 1'b1, 32'd5,         4'hF, 32'h0};
      for (int k = 0; k < 4; k++) begin
         if (ops[k].wr) begin
            push_exp(1'b1, 32'h0);
            model_write(ops[k].a, ops[k].be, ops[k].d);
         end else begin
            push_exp(1'b0, model_read(ops[k].a));
         end
         access(1'b0, ops[k].wr, ops[k].rd, ops[k].a, ops[k].be, ops[k].d, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
         e = exp_q.pop_front();
         checks++;
         if (gw !== e.wr || gr !== !e.wr || (!e.wr && dout !== e.data)) begin
            errors++;
            $display("FAIL addr_op%0d: got wr=%b rd=%b data=%h required wr=%b data=%h", k, gw, gr, dout, e.wr, e.data);
         end
         checks++;
         if (AddrErr !== (k >= 1)) begin
            errors++;
            $display("FAIL addr_err_op%0d: got %b required %b", k, AddrErr, (k >= 1));
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int stray;
      logic gw, gr;
      logic [31:0] dout;
      access(1'b1, 1'b1, 1'b0, 32'd9, 4'hF, 32'h12345678, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
      checks++;
      if (gw !== 1'b1) begin
         errors++;
         $display("FAIL midreset_prior_write: got wrack=%b required 1", gw);
      end
      @(negedge Clk);
      addr_w3 = 32'd9; data_in_w3 = 32'h87654321; we_w3 = 1'b1;
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      $display("  reset asserted during wait of write addr=9");
      checks++;
      if ({wr_ack_w3, rd_ack_w3, addr_err_w3, proto_err_w3, data_out_w3} !== 36'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got wr=%b rd=%b ae=%b pe=%b data=%h required all 0", wr_ack_w3, rd_ack_w3, addr_err_w3, proto_err_w3, data_out_w3);
      end
      checks++;
      if (AddrErr !== 1'b0 || ProtoErr !== 1'b0) begin
         errors++;
         $display("FAIL midreset_flags_dut0: got ae=%b pe=%b required 0 0", AddrErr, ProtoErr);
      end
      we_w3 = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      stray = 0;
      repeat (8) begin
         @(negedge Clk);
         if (wr_ack_w3 || rd_ack_w3) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL midreset_idle: got %0d acks after reset required 0", stray);
      end
      access(1'b1, 1'b0, 1'b1, 32'd9, 4'hF, 32'h0, 12'd0, 1'b0, 1'b0, lat, gw, gr, dout);
      checks++;
      if (gr !== 1'b1 || dout !== 32'h12345678) begin
         errors++;
         $display("FAIL midreset_readback: got rdack=%b data=%h required rdack=1 data=12345678", gr, dout);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_byte_enables();
      test_burst();
      test_wait_states();
      test_errors();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vproc_mem_responder.md
Name: vproc_mem_responder

Overview:
- Bus responder (target) for the VProc virtual-processor initiator interface. Sits on the far side of the initiator's Addr/WE/RD/BE/DataOut/DataIn/WRAck/RDAck bus.
- Backed by a word-wide RAM; responds to single and burst accesses with configurable wait states.
- Flags protocol and address errors.
- Used as the default memory/register target in co-simulation benches.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words.
- BASE_ADDR, 32'h0000_0000, base of decoded window; must be aligned to window size.
- WORD_ADDR, 1, 1: Addr is a word index (burst increment 1); 0: Addr is a byte address, word index = Addr[ADDR_WIDTH+1:2].
- WAIT_STATES, 0, extra cycles inserted before each ack (0..15).

Ports:
- Clk, input, 1, clock; all state updates on rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- Addr, input, 32, access address from initiator.
- BE, input, 4, byte enables; BE[i] covers bits 8i+7:8i.
- WE, input, 1, write request, level, held until acked.
- RD, input, 1, read request, level, held until acked.
- DataIn, input, 32, write data from initiator.
- Burst, input, 12, burst length (0 = single access).
- BurstFirst, input, 1, first beat of burst.
- BurstLast, input, 1, last beat of burst.
- DataOut, output, 32, read data to initiator.
- WRAck, output, 1, write acknowledge, one-cycle pulse.
- RDAck, output, 1, read acknowledge, one-cycle pulse.
- AddrErr, output, 1, sticky: access outside window.
- ProtoErr, output, 1, sticky: protocol violation.

Behaviour:
Reset (async assert, sync release):
- DataOut=0, WRAck=0, RDAck=0, AddrErr=0, ProtoErr=0, FSM=IDLE, wait counter=0, beat counter=0.
- RAM contents are not reset.
- Reset mid-access drops the access; an unacked write does not commit.

FSM states and transitions:
- IDLE: on an edge sampling (WE|RD)=1:
  - WAIT_STATES=0 goes straight to ACK.
  - Otherwise load wait counter = WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each edge; at 0 go to ACK.
- The ack register is set on the edge entering ACK, so WRAck/RDAck are high for exactly one cycle. Latency from request-sampled edge to ack-high is WAIT_STATES cycles.
- On the edge that sets the ack:
  - Writes commit to RAM for each byte with BE[i]=1.
  - Reads load DataOut from RAM.
  - Addr/BE/DataIn are sampled on this edge, not at request start.
- ACK: unconditionally return to IDLE. The request still visible during ACK is the old beat and is never re-serviced. The next beat is sampled in IDLE one cycle later, so the maximum rate is one beat per 2 cycles.
- DataOut holds its value until the next read ack.

Address decode:
- In window if the bits of Addr above the index field equal the same bits of BASE_ADDR; index wraps within ADDR_WIDTH.
- Out of window: still acked (initiator must never hang); write dropped, DataOut=0, AddrErr set.

Error and burst rules:
- WE and RD both high at the sampling edge: treat as write, set ProtoErr.
- Burst tracking:
  - On an acked beat with BurstFirst=1, beat counter = Burst-1.
  - Each subsequent acked beat decrements the counter.
  - ProtoErr is set if BurstLast=1 while counter!=0, if counter reaches 0 without BurstLast, or if BurstFirst arrives while counter!=0.
  - Burst=1 requires BurstFirst and BurstLast on the same beat.
  - Burst=0 accesses are not tracked.
- Sticky flags clear only on Reset.

Optional Feature:
- Macro: VPROC_RESP_RAND_WAIT_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on Reset) advances every Clk. At each request start, LFSR[1:0] (0..3) is added to WAIT_STATES for that beat.
- Undefined: the LFSR is absent and latency is exactly WAIT_STATES.

Decomposition:
- Shared package vproc_resp_pkg holds:
  - the FSM state enum (IDLE, WAIT, ACK);
  - the LFSR seed/tap constants;
  - the byte-lane mask function;
  - a BURST_W=12 constant.
- One natural sub-module: vproc_resp_ram, a byte-enabled single-port RAM with synchronous write/read, instanced by the responder.

Test Plan:
- Single write then read, WAIT_STATES=0:
  - Write Addr=5, BE=4'hF, DataIn=32'hDEADBEEF; read Addr=5.
  - WRAck high in the cycle after request sampled; RDAck high likewise with DataOut=32'hDEADBEEF.
- Byte enables:
  - Write 32'h11223344 to Addr=7, then write 32'hAABBCCDD with BE=4'b0101.
  - Read returns 32'h11BB33DD.
- Wait states, WAIT_STATES=3:
  - Read request sampled at edge N; RDAck high only during cycle N+3..N+4.
  - No second ack while RD is still held in the ACK cycle.
- Burst write of 4 beats, Burst=4, Addr 16..19, data 1..4:
  - Four WRAck pulses, each separated by at least one low cycle.
  - Readback gives 1,2,3,4; ProtoErr=0.
- Protocol and address errors (ADDR_WIDTH=10, BASE_ADDR=0):
  - Burst=3 with BurstLast on beat 2: ProtoErr=1.
  - Read Addr=32'h0000_0400: acked, DataOut=0, AddrErr=1.
  - WE=RD=1: write commits and ProtoErr=1.
- Reset mid-access:
  - Assert Reset during WAIT of a write to Addr=9.
  - Acks drop immediately, state IDLE, flags 0, and a subsequent read of Addr=9 returns the prior contents.
